bit_window_analyzer: RTL and testbench

//  Collects user-entered bits from two buttons (btn1 = '1', btn2 = '0') into a DEPTH-deep window.
//  On request, serially counts the selected bit value and compares the count against THRESHOLD.

---
 rtl/bwa_pkg.sv | 11 +
 rtl/rise_detect.sv | 21 ++
 rtl/bit_window_analyzer.sv | 138 +++++++++++++
 tb/tb_bit_window_analyzer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bwa_pkg.sv
// rtl/bwa_pkg.sv - shared state type for the bit window analyzer
package bwa_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COUNT   = 2'd2,
    DONE    = 2'd3
  } bwa_state_t;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - registered single-bit rising-edge detector
module rise_detect (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_d;
    end
  end

  assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/bit_window_analyzer.sv
// rtl/bit_window_analyzer.sv - button-fed bit window with serial count and threshold compare
module bit_window_analyzer
  import bwa_pkg::*;
#(
  parameter  int DEPTH      = 4,
  parameter  int THRESHOLD  = 2,
  parameter  int COUNT_ONES = 1,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_btn1,
  input  logic             i_btn2,
  input  logic             i_waiting_for_user,
  input  logic             i_start_verification,
  output logic             o_final_analysis,
  output logic             o_result_valid,
  output logic             o_incomplete,
  output logic             o_busy,
  output logic [DEPTH-1:0] o_window,
  output logic [CNT_W-1:0] o_digit_count,
  output logic [CNT_W-1:0] o_bit_count
);

  localparam int   IDX_W    = $clog2(DEPTH);
  localparam logic LP_MATCH = 1'(COUNT_ONES);

  bwa_state_t       r_state;
  bwa_state_t       w_next;
  logic [DEPTH-1:0] r_window;
  logic [DEPTH-1:0] r_snap;
  logic [CNT_W-1:0] r_digit_count;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_bit_count;
  logic             r_final;
  logic             r_valid;
  logic             r_incomplete;
  logic             r_start_lock;
  logic             w_rise1;
  logic             w_rise2;
  logic             w_start;

  rise_detect u_rise_btn1 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_btn1),
    .o_rise  (w_rise1)
  );

  rise_detect u_rise_btn2 (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_btn2),
    .o_rise  (w_rise2)
  );

  // A start level held through an analysis must drop before it can trigger another one.
  assign w_start = i_start_verification & ~r_start_lock;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (i_waiting_for_user) w_next = COLLECT;
      COLLECT: begin
        if (w_start) begin
          w_next = COUNT;
        end else if (!i_waiting_for_user) begin
          w_next = IDLE;
        end
      end
      COUNT:   if (r_idx == IDX_W'(DEPTH - 1)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_window      <= '0;
      r_snap        <= '0;
      r_digit_count <= '0;
      r_idx         <= '0;
      r_acc         <= '0;
      r_bit_count   <= '0;
      r_final       <= 1'b0;
      r_valid       <= 1'b0;
      r_incomplete  <= 1'b0;
      r_start_lock  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (!i_start_verification) r_start_lock <= 1'b0;
      case (r_state)
        COLLECT: begin
          if (w_start) begin
            r_snap       <= r_window;
            r_acc        <= '0;
            r_idx        <= '0;
            r_start_lock <= 1'b1;
          end else if (w_rise1 ^ w_rise2) begin
            r_window <= {r_window[DEPTH-2:0], w_rise1};
            if (r_digit_count != CNT_W'(DEPTH)) r_digit_count <= r_digit_count + 1'b1;
          end
        end
        COUNT: begin
          r_acc <= r_acc + CNT_W'(r_snap[r_idx] == LP_MATCH);
          r_idx <= r_idx + 1'b1;
        end
        DONE: begin
          r_bit_count   <= r_acc;
          r_final       <= (r_acc >= CNT_W'(THRESHOLD));
          r_incomplete  <= (r_digit_count < CNT_W'(DEPTH));
          r_valid       <= 1'b1;
          r_window      <= '0;
          r_digit_count <= '0;
        end
        default: ;
      endcase
    end
  end

  assign o_final_analysis = r_final;
  assign o_result_valid   = r_valid;
  assign o_incomplete     = r_incomplete;
  assign o_busy           = (r_state == COUNT) || (r_state == DONE);
  assign o_window         = r_window;
  assign o_digit_count    = r_digit_count;
  assign o_bit_count      = r_bit_count;

endmodule

// File: tb/tb_bit_window_analyzer.sv
// tb/tb_bit_window_analyzer.sv - scoreboard bench for two analyzer configurations
module tb_bit_window_analyzer;

  localparam int AD = 4;
  localparam int BD = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       a_btn1, a_btn2, a_wait, a_start;
  logic       a_final, a_valid, a_inc, a_busy;
  logic [3:0] a_window;
  logic [2:0] a_dc, a_bc;

  logic       b_btn1, b_btn2, b_wait, b_start;
  logic       b_final, b_valid, b_inc, b_busy;
  logic [7:0] b_window;
  logic [3:0] b_dc, b_bc;

  bit_window_analyzer #(.DEPTH(AD), .THRESHOLD(2), .COUNT_ONES(1)) u_dut_a (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_btn1               (a_btn1),
    .i_btn2               (a_btn2),
    .i_waiting_for_user   (a_wait),
    .i_start_verification (a_start),
    .o_final_analysis     (a_final),
    .o_result_valid       (a_valid),
    .o_incomplete         (a_inc),
    .o_busy               (a_busy),
    .o_window             (a_window),
    .o_digit_count        (a_dc),
    .o_bit_count          (a_bc)
  );

  bit_window_analyzer #(.DEPTH(BD), .THRESHOLD(5), .COUNT_ONES(0)) u_dut_b (
    .i_clk                (clk),
    .i_rst_n              (rst_n),
    .i_btn1               (b_btn1),
    .i_btn2               (b_btn2),
    .i_waiting_for_user   (b_wait),
    .i_start_verification (b_start),
    .o_final_analysis     (b_final),
    .o_result_valid       (b_valid),
    .o_incomplete         (b_inc),
    .o_busy               (b_busy),
    .o_window             (b_window),
    .o_digit_count        (b_dc),
    .o_bit_count          (b_bc)
  );

  typedef struct {
    logic [3:0] bc;
    logic       fin;
    logic       inc;
    int         due;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t ea, eb;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && a_valid) begin
      n_checks++;
      if (sb_a.size() == 0) begin
        $display("FAIL a_unexpected_valid actual=1 required=0 cyc=%0d", cyc);
      end else begin
        ea = sb_a.pop_front();
        if ({1'b0, a_bc} !== ea.bc || a_final !== ea.fin || a_inc !== ea.inc || cyc != ea.due)
          $display("FAIL a_result actual bc=%0d fin=%0b inc=%0b cyc=%0d required bc=%0d fin=%0b inc=%0b cyc=%0d",
                   a_bc, a_final, a_inc, cyc, ea.bc, ea.fin, ea.inc, ea.due);
        else n_pass++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_valid) begin
      n_checks++;
      if (sb_b.size() == 0) begin
        $display("FAIL b_unexpected_valid actual=1 required=0 cyc=%0d", cyc);
      end else begin
        eb = sb_b.pop_front();
        if (b_bc !== eb.bc || b_final !== eb.fin || b_inc !== eb.inc || cyc != eb.due)
          $display("FAIL b_result actual bc=%0d fin=%0b inc=%0b cyc=%0d required bc=%0d fin=%0b inc=%0b cyc=%0d",
                   b_bc, b_final, b_inc, cyc, eb.bc, eb.fin, eb.inc, eb.due);
        else n_pass++;
      end
    end
  end

  task automatic press_a(input logic v);
    @(negedge clk);
    if (v) a_btn1 = 1'b1; else a_btn2 = 1'b1;
    @(negedge clk);
    a_btn1 = 1'b0;
    a_btn2 = 1'b0;
  endtask

  task automatic enter_a(input logic [7:0] bits, input int n);
    logic [7:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) press_a(v[i]);
  endtask

  task automatic press_b(input logic v);
    @(negedge clk);
    if (v) b_btn1 = 1'b1; else b_btn2 = 1'b1;
    @(negedge clk);
    b_btn1 = 1'b0;
    b_btn2 = 1'b0;
  endtask

  task automatic start_a(input logic [3:0] bc, input logic fin, input logic inc);
    exp_t e;
    @(negedge clk);
    e.bc = bc; e.fin = fin; e.inc = inc; e.due = cyc + AD + 2;
    sb_a.push_back(e);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic drain_a();
    for (int i = 0; i < 40; i++) begin
      if (sb_a.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {a_btn1, a_btn2, a_wait, a_start} = '0;
    {b_btn1, b_btn2, b_wait, b_start} = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({a_final, a_valid, a_inc, a_busy, a_window, a_dc, a_bc} !== 14'd0)
      $display("FAIL reset_a actual=%h required=0", {a_final, a_valid, a_inc, a_busy, a_window, a_dc, a_bc});
    else n_pass++;
    n_checks++;
    if ({b_final, b_valid, b_inc, b_busy, b_window, b_dc, b_bc} !== 20'd0)
      $display("FAIL reset_b actual=%h required=0", {b_final, b_valid, b_inc, b_busy, b_window, b_dc, b_bc});
    else n_pass++;
    rst_n = 1'b1;
    a_wait = 1'b1;
    b_wait = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    enter_a(8'b1011, 4);
    n_checks++;
    if (a_window !== 4'b1011 || a_dc !== 3'd4)
      $display("FAIL basic_window actual=%b/%0d required=1011/4", a_window, a_dc);
    else n_pass++;
    start_a(4'd3, 1'b1, 1'b0);
    n_checks++;
    if (a_busy !== 1'b1) $display("FAIL basic_busy actual=%b required=1", a_busy);
    else n_pass++;
    drain_a();
    n_checks++;
    if (sb_a.size() != 0) $display("FAIL basic_timeout actual=%0d required=0", sb_a.size());
    else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (a_final !== 1'b1 || a_bc !== 3'd3 || a_window !== 4'd0 || a_dc !== 3'd0)
      $display("FAIL basic_hold actual=%b/%0d/%b/%0d required=1/3/0000/0", a_final, a_bc, a_window, a_dc);
    else n_pass++;
  endtask

  task automatic test_low_count();
    enter_a(8'b1000, 4);
    start_a(4'd1, 1'b0, 1'b0);
    drain_a();
    n_checks++;
    if (sb_a.size() != 0 || a_window !== 4'd0 || a_dc !== 3'd0 || a_final !== 1'b0)
      $display("FAIL low_count actual=%0d/%b/%0d/%b required=0/0000/0/0", sb_a.size(), a_window, a_dc, a_final);
    else n_pass++;
  endtask

  task automatic test_sliding();
    enter_a(8'b110001, 6);
    n_checks++;
    if (a_window !== 4'b0001 || a_dc !== 3'd4)
      $display("FAIL sliding_window actual=%b/%0d required=0001/4", a_window, a_dc);
    else n_pass++;
    start_a(4'd1, 1'b0, 1'b0);
    drain_a();
    n_checks++;
    if (sb_a.size() != 0) $display("FAIL sliding_timeout actual=%0d required=0", sb_a.size());
    else n_pass++;
  endtask

  task automatic test_both_and_short();
    @(negedge clk);
    a_btn1 = 1'b1;
    a_btn2 = 1'b1;
    @(negedge clk);
    a_btn1 = 1'b0;
    a_btn2 = 1'b0;
    n_checks++;
    if (a_window !== 4'd0 || a_dc !== 3'd0)
      $display("FAIL both_buttons actual=%b/%0d required=0000/0", a_window, a_dc);
    else n_pass++;
    enter_a(8'b11, 2);
    n_checks++;
    if (a_window !== 4'b0011 || a_dc !== 3'd2)
      $display("FAIL short_window actual=%b/%0d required=0011/2", a_window, a_dc);
    else n_pass++;
    start_a(4'd2, 1'b1, 1'b1);
    drain_a();
    n_checks++;
    if (sb_a.size() != 0 || a_inc !== 1'b1) $display("FAIL short_incomplete actual=%b required=1", a_inc);
    else n_pass++;
  endtask

  task automatic test_start_held();
    exp_t e;
    enter_a(8'b1111, 4);
    @(negedge clk);
    e.bc = 4'd4; e.fin = 1'b1; e.inc = 1'b0; e.due = cyc + AD + 2;
    sb_a.push_back(e);
    a_start = 1'b1;
    repeat (30) @(negedge clk);
    n_checks++;
    if (sb_a.size() != 0 || a_busy !== 1'b0)
      $display("FAIL start_held actual=%0d/%b required=0/0", sb_a.size(), a_busy);
    else n_pass++;
    a_start = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_count();
    enter_a(8'b1011, 4);
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (a_busy !== 1'b1) $display("FAIL mid_busy actual=%b required=1", a_busy);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_final, a_valid, a_inc, a_busy, a_window, a_dc, a_bc} !== 14'd0)
      $display("FAIL mid_reset actual=%h required=0", {a_final, a_valid, a_inc, a_busy, a_window, a_dc, a_bc});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    n_checks++;
    if (a_final !== 1'b0 || a_bc !== 3'd0 || a_busy !== 1'b0)
      $display("FAIL mid_no_result actual=%b/%0d/%b required=0/0/0", a_final, a_bc, a_busy);
    else n_pass++;
  endtask

  task automatic test_count_zeros();
    logic [7:0] v;
    exp_t e;
    v = 8'b00010010;
    for (int i = 7; i >= 0; i--) press_b(v[i]);
    n_checks++;
    if (b_window !== 8'b00010010 || b_dc !== 4'd8)
      $display("FAIL zeros_window actual=%b/%0d required=00010010/8", b_window, b_dc);
    else n_pass++;
    @(negedge clk);
    e.bc = 4'd6; e.fin = 1'b1; e.inc = 1'b0; e.due = cyc + BD + 2;
    sb_b.push_back(e);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (sb_b.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    n_checks++;
    if (sb_b.size() != 0 || b_window !== 8'd0)
      $display("FAIL zeros_done actual=%0d/%b required=0/00000000", sb_b.size(), b_window);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_low_count();
    test_sliding();
    test_both_and_short();
    test_start_held();
    test_reset_mid_count();
    test_count_zeros();
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
